// File: rtl/sample_ram_mc_if.sv
// Bus bundle for sample_ram_mc: the CPU read/write port plus the per-channel sample
// streams and ring status. The master side drives requests; the slave side is the RAM.
interface sample_ram_mc_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int NUM_CH        = 2,
    parameter int CH_DEPTH_LOG2 = 8
);
    logic                              wEn;
    logic [ADDRESS_WIDTH-1:0]          addr;
    logic [DATA_WIDTH-1:0]             dataIn;
    logic [DATA_WIDTH-1:0]             dataOut;
    logic [NUM_CH-1:0]                 ch_valid;
    logic [NUM_CH-1:0]                 ch_ready;
    logic [NUM_CH*DATA_WIDTH-1:0]      ch_data;
    logic [NUM_CH-1:0]                 ch_clear;
    logic [NUM_CH*CH_DEPTH_LOG2-1:0]   ch_wptr;
    logic [NUM_CH-1:0]                 ch_wrapped;

    modport master (
        output wEn, addr, dataIn, ch_valid, ch_data, ch_clear,
        input  dataOut, ch_ready, ch_wptr, ch_wrapped
    );

    modport slave (
        input  wEn, addr, dataIn, ch_valid, ch_data, ch_clear,
        output dataOut, ch_ready, ch_wptr, ch_wrapped
    );
endinterface

// File: rtl/sample_ram_mc.sv
// Shared sample RAM: CPU port with write priority plus NUM_CH round-robin arbitrated
// sample channels, each writing into its own hardware-managed ring region.
module sample_ram_mc #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int NUM_CH        = 2,
    parameter int CH_DEPTH_LOG2 = 8,
    parameter int CH_BASE       = 3584
) (
    input  logic            clk,
    input  logic            reset,
    sample_ram_mc_if.slave  bus
);
    localparam int DEPTH = 2**ADDRESS_WIDTH;
    localparam int RING  = 2**CH_DEPTH_LOG2;
    localparam int RR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("sample_ram_mc: NUM_CH must be in 1..8");
    end
    if (CH_BASE + NUM_CH*RING > DEPTH) begin : g_bad_region
        $error("sample_ram_mc: channel regions exceed the array");
    end

    logic [NUM_CH-1:0]        pending_vec;
    logic [NUM_CH-1:0]        wrapped_vec;
    logic [DATA_WIDTH-1:0]    hold_arr [NUM_CH];
    logic [CH_DEPTH_LOG2-1:0] wptr_arr [NUM_CH];

    logic [RR_W-1:0]          rr_reg;
    logic [RR_W-1:0]          rr_next;
    logic [NUM_CH-1:0]        above_rr;
    logic [NUM_CH-1:0]        req_hi;
    logic [NUM_CH-1:0]        grant;
    logic                     grant_valid;
    logic [RR_W-1:0]          grant_idx;
    logic [DATA_WIDTH-1:0]    grant_data;
    logic [CH_DEPTH_LOG2-1:0] grant_wptr;

    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [DATA_WIDTH-1:0]    mem_array [DEPTH];
    logic [DATA_WIDTH-1:0]    dout_reg;

    // Channels at or after the round-robin pointer get first pick.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rr_mask
        assign above_rr[gi] = (RR_W'(gi) >= rr_reg);
        assign grant[gi]    = grant_valid && (grant_idx == RR_W'(gi));
    end

    always_comb begin
        req_hi      = pending_vec & above_rr;
        grant_valid = 1'b0;
        grant_idx   = '0;
        // A held sample may never be written while reset is asserted.
        if (!bus.wEn && !reset) begin
            for (int i = NUM_CH-1; i >= 0; i--) begin
                if (pending_vec[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = RR_W'(i);
                end
            end
            for (int i = NUM_CH-1; i >= 0; i--) begin
                if (req_hi[i]) begin
                    grant_idx = RR_W'(i);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        grant_wptr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                grant_data = hold_arr[i];
                grant_wptr = wptr_arr[i];
            end
        end
    end

    always_comb begin
        rr_next = rr_reg;
        if (grant_valid) begin
            rr_next = (grant_idx == RR_W'(NUM_CH-1)) ? '0 : grant_idx + RR_W'(1);
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (bus.wEn) begin
            mem_we    = 1'b1;
            mem_waddr = bus.addr;
            mem_wdata = bus.dataIn;
        end else if (grant_valid) begin
            mem_we    = 1'b1;
            mem_waddr = ADDRESS_WIDTH'(CH_BASE)
                      + (ADDRESS_WIDTH'(grant_idx) << CH_DEPTH_LOG2)
                      + ADDRESS_WIDTH'(grant_wptr);
            mem_wdata = grant_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_array[mem_waddr] <= mem_wdata;
        end
    end

    // Read-first: a same-cycle write to addr is not visible until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_reg <= '0;
        end else begin
            dout_reg <= mem_array[bus.addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_reg <= '0;
        end else begin
            rr_reg <= rr_next;
        end
    end

    assign bus.dataOut  = dout_reg;
    assign bus.ch_ready = ~pending_vec | grant;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic                     handshake;
        logic                     pend_reg;
        logic                     wrap_reg;
        logic [CH_DEPTH_LOG2-1:0] ptr_reg;
        logic [DATA_WIDTH-1:0]    hold_reg;

        assign handshake = bus.ch_valid[gi] & bus.ch_ready[gi];

        always_ff @(posedge clk) begin
            if (reset) begin
                pend_reg <= 1'b0;
                ptr_reg  <= '0;
                wrap_reg <= 1'b0;
            end else begin
                if (handshake) begin
                    pend_reg <= 1'b1;
                end else if (grant[gi]) begin
                    pend_reg <= 1'b0;
                end
                // Clear wins over the pointer advance; the granted word still uses the old pointer.
                if (bus.ch_clear[gi]) begin
                    ptr_reg  <= '0;
                    wrap_reg <= 1'b0;
                end else if (grant[gi]) begin
                    ptr_reg <= ptr_reg + CH_DEPTH_LOG2'(1);
                    if (&ptr_reg) begin
                        wrap_reg <= 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (handshake) begin
                hold_reg <= bus.ch_data[gi*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        assign pending_vec[gi]                                = pend_reg;
        assign wrapped_vec[gi]                                = wrap_reg;
        assign hold_arr[gi]                                   = hold_reg;
        assign wptr_arr[gi]                                   = ptr_reg;
        assign bus.ch_wptr[gi*CH_DEPTH_LOG2 +: CH_DEPTH_LOG2] = ptr_reg;
    end

    assign bus.ch_wrapped = wrapped_vec;
endmodule

// File: tb/tb_sample_ram_mc.sv
// Scoreboard bench for sample_ram_mc: driver pushes expectations computed from a
// ring-buffer/memory reference model, a monitor pops and compares them.
module tb_sample_ram_mc;
    localparam int DW   = 32;
    localparam int AW   = 12;
    localparam int NC   = 2;
    localparam int DL   = 8;
    localparam int BASE = 3584;
    localparam int RING = 256;

    typedef enum int {K_DOUT, K_READY, K_WPTR, K_WRAP} kind_t;
    typedef struct {
        kind_t       kind;
        int          ch;
        int          due;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    chk_t        sb[$];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] mem_m [int];
    int          cnt [NC];
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [1:0]  gate      = 2'b11;
    logic        rdy_chk_en = 1'b0;
    logic [1:0]  rdy_exp   = 2'b11;
    logic        model_on  = 1'b1;
    logic        rst_drv   = 1'b0;

    sample_ram_mc_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_CH(NC), .CH_DEPTH_LOG2(DL)) bif ();

    sample_ram_mc #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_CH(NC), .CH_DEPTH_LOG2(DL), .CH_BASE(BASE)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bif)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(kind_t k, int ch, int due, logic [31:0] e, string nm);
        chk_t t;
        t.kind = k; t.ch = ch; t.due = due; t.exp = e; t.name = nm;
        sb.push_back(t);
    endfunction

    // Reference model: channel c's n-th accepted sample (since reset/clear) lands in slot n mod RING.
    function automatic void model_accept(int c, logic [31:0] data);
        int a;
        a = BASE + c*RING + (cnt[c] % RING);
        mem_m[a] = data;
        cnt[c]++;
    endfunction

    initial forever begin
        @(negedge clk);
        #2;
        for (int i = sb.size()-1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                logic [31:0] act;
                case (sb[i].kind)
                    K_DOUT:  act = bif.dataOut;
                    K_READY: act = {30'b0, bif.ch_ready};
                    K_WPTR:  act = 32'(bif.ch_wptr[sb[i].ch*DL +: DL]);
                    default: act = 32'(bif.ch_wrapped[sb[i].ch]);
                endcase
                n_checks++;
                if (act !== sb[i].exp) begin
                    n_err++;
                    $display("FAIL %s ch=%0d cyc=%0d got=%h expected=%h",
                             sb[i].name, sb[i].ch, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick(input logic we, input logic [11:0] a, input logic [31:0] d,
                        input logic rd, input logic [1:0] clr);
        logic [1:0]  v;
        logic [1:0]  acc;
        logic [63:0] cd;
        logic [31:0] s;
        @(negedge clk);
        v  = 2'b00;
        cd = '0;
        if (q0.size() > 0 && gate[0]) begin v[0] = 1'b1; cd[31:0]  = q0[0]; end
        if (q1.size() > 0 && gate[1]) begin v[1] = 1'b1; cd[63:32] = q1[0]; end
        bif.wEn = we; bif.addr = a; bif.dataIn = d;
        bif.ch_valid = v; bif.ch_data = cd; bif.ch_clear = clr;
        rst = rst_drv;
        #1;
        acc = v & bif.ch_ready;
        if (rdy_chk_en) begin
            push(K_READY, -1, cyc, {30'b0, rdy_exp}, "ready");
            rdy_chk_en = 1'b0;
        end
        if (rd && mem_m.exists(int'(a))) push(K_DOUT, -1, cyc + 1, mem_m[int'(a)], "dout");
        if (rst_drv) begin
            push(K_DOUT,  -1, cyc + 1, 32'h0, "reset_dout");
            push(K_READY, -1, cyc + 1, 32'h3, "reset_ready");
            for (int c = 0; c < NC; c++) begin
                push(K_WPTR, c, cyc + 1, 32'h0, "reset_wptr");
                push(K_WRAP, c, cyc + 1, 32'h0, "reset_wrapped");
            end
        end else begin
            if (we) mem_m[int'(a)] = d;
            if (acc[0]) begin s = q0.pop_front(); if (model_on) model_accept(0, s); end
            if (acc[1]) begin s = q1.pop_front(); if (model_on) model_accept(1, s); end
            for (int c = 0; c < NC; c++) if (clr[c]) cnt[c] = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 12'd0, 32'd0, 1'b0, 2'b00);
    endtask

    task automatic rd_chk(input int a);
        tick(1'b0, 12'(a), 32'd0, 1'b1, 2'b00);
    endtask

    task automatic chk_state();
        for (int c = 0; c < NC; c++) begin
            push(K_WPTR, c, cyc, 32'(cnt[c] % RING), "wptr");
            push(K_WRAP, c, cyc, (cnt[c] >= RING) ? 32'h1 : 32'h0, "wrapped");
        end
    endtask

    task automatic do_reset();
        q0.delete(); q1.delete();
        rst_drv = 1'b1;
        idle(1);
        rst_drv = 1'b0;
        for (int c = 0; c < NC; c++) cnt[c] = 0;
    endtask

    task automatic run_stream(input int maxc);
        int i;
        i = 0;
        while ((q0.size() > 0 || q1.size() > 0) && i < maxc) begin
            idle(1);
            i++;
        end
        n_checks++;
        if (q0.size() > 0 || q1.size() > 0) begin
            n_err++;
            $display("FAIL stream_timeout left0=%0d left1=%0d expected=0", q0.size(), q1.size());
            q0.delete(); q1.delete();
        end
        idle(4);
    endtask

    initial begin
        logic [1:0] rtab [7];
        bif.wEn = 1'b0; bif.addr = '0; bif.dataIn = '0;
        bif.ch_valid = '0; bif.ch_data = '0; bif.ch_clear = '0;
        for (int c = 0; c < NC; c++) cnt[c] = 0;

        // Single sample on ch0, then read it back.
        do_reset();
        q0.push_back(32'hA5);
        idle(2);
        rd_chk(BASE);
        chk_state();
        idle(1);

        // Both channels stream four samples; grants alternate.
        do_reset();
        for (int i = 1; i <= 4; i++) begin q0.push_back(32'(i)); q1.push_back(32'(i + 16)); end
        rtab[0] = 2'b11; rtab[1] = 2'b01; rtab[2] = 2'b10; rtab[3] = 2'b01;
        rtab[4] = 2'b10; rtab[5] = 2'b01; rtab[6] = 2'b10;
        for (int i = 0; i < 7; i++) begin
            rdy_exp = rtab[i]; rdy_chk_en = 1'b1;
            idle(1);
        end
        run_stream(20);
        chk_state();
        for (int i = 0; i < 4; i++) begin rd_chk(BASE + i); rd_chk(BASE + RING + i); end

        // CPU holds the port for 5 cycles while ch0 offers two samples.
        do_reset();
        q0.push_back(32'h7); q0.push_back(32'h8);
        for (int i = 0; i < 5; i++) begin
            rdy_exp = (i == 0) ? 2'b11 : 2'b10; rdy_chk_en = 1'b1;
            tick(1'b1, 12'(100 + i), $urandom, 1'b0, 2'b00);
        end
        rdy_exp = 2'b11; rdy_chk_en = 1'b1;
        idle(1);
        rd_chk(BASE);
        rd_chk(BASE + 1);
        for (int i = 0; i < 5; i++) rd_chk(100 + i);
        chk_state();

        // Ring wrap on ch1 after 256 writes, then clear while idle.
        do_reset();
        for (int i = 0; i < 255; i++) q1.push_back($urandom);
        run_stream(400);
        chk_state();
        q1.push_back($urandom);
        run_stream(10);
        chk_state();
        q1.push_back($urandom);
        run_stream(10);
        chk_state();
        rd_chk(BASE + RING);
        rd_chk(BASE + RING + 1);
        tick(1'b0, 12'd0, 32'd0, 1'b0, 2'b10);
        idle(1);
        chk_state();

        // Clear coinciding with a grant at pointer 5.
        do_reset();
        for (int i = 0; i < 5; i++) q0.push_back($urandom);
        run_stream(20);
        chk_state();
        q0.push_back(32'hC0DE_0005);
        idle(1);
        tick(1'b0, 12'd0, 32'd0, 1'b0, 2'b01);
        idle(1);
        chk_state();
        rd_chk(BASE + 5);

        // Reset while ch0 is pending with valid held: held sample is discarded.
        do_reset();
        tick(1'b1, 12'(BASE), 32'hCAFE_F00D, 1'b0, 2'b00);
        model_on = 1'b0;
        q0.push_back(32'hDEAD_BEEF); q0.push_back(32'hDEAD_BEEF);
        tick(1'b1, 12'd200, 32'h1234, 1'b0, 2'b00);
        rst_drv = 1'b1;
        idle(1);
        rst_drv = 1'b0;
        q0.delete();
        model_on = 1'b1;
        for (int c = 0; c < NC; c++) cnt[c] = 0;
        rdy_exp = 2'b11; rdy_chk_en = 1'b1;
        idle(3);
        rd_chk(BASE);
        chk_state();

        // Randomized mix of CPU traffic and both channels streaming.
        do_reset();
        for (int i = 0; i < 64; i++) tick(1'b1, 12'(i), $urandom, 1'b0, 2'b00);
        for (int k = 0; k < 400; k++) begin
            if (q0.size() < 2 && $urandom_range(1, 0) == 1) q0.push_back($urandom);
            if (q1.size() < 2 && $urandom_range(1, 0) == 1) q1.push_back($urandom);
            gate[0] = ($urandom_range(3, 0) != 0);
            gate[1] = ($urandom_range(3, 0) != 0);
            tick($urandom_range(3, 0) == 0, 12'($urandom_range(63, 0)), $urandom, 1'b1, 2'b00);
        end
        gate = 2'b11;
        run_stream(50);
        chk_state();
        for (int a = BASE; a < BASE + NC*RING; a++) begin
            if (mem_m.exists(a) && (a % 4 == 0)) rd_chk(a);
        end

        idle(3);
        n_checks++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
